// File: rtl/regfile_sb.sv
// ============================================================================
// Module  : regfile_sb
// Brief   : Two-read/one-write register file with bypass, pending-write
//           scoreboard, debug read port and synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic [ADDR_W:0]   busy_cnt,
    input  logic [ADDR_W-1:0] test_addr,
    output logic [DATA_W-1:0] test_data
);

    localparam int c_NREG   = 2 ** ADDR_W;
    localparam bit c_BYPASS = (BYPASS != 0);

    logic [DATA_W-1:0] r_rf [c_NREG];
    logic [c_NREG-1:0] r_pending;
    logic [ADDR_W:0]   r_busy_cnt;

    logic              w_we;
    logic              w_mk;
    logic              w_set;
    logic              w_clr;
    logic [c_NREG-1:0] w_pending_nxt;

    assign w_we  = wen && (waddr != '0);
    assign w_mk  = mark_en && (mark_addr != '0);
    assign w_set = w_mk && !r_pending[mark_addr];
    // A write to the register being re-marked keeps it pending, so no clear.
    assign w_clr = w_we && r_pending[waddr] && !(w_mk && (waddr == mark_addr));

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_we) w_pending_nxt[waddr] = 1'b0;
        if (w_mk) w_pending_nxt[mark_addr] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < c_NREG; i++) r_rf[i] <= '0;
            r_pending  <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_we) r_rf[waddr] <= wdata;
            r_pending  <= w_pending_nxt;
            r_busy_cnt <= r_busy_cnt + (ADDR_W+1)'(w_set) - (ADDR_W+1)'(w_clr);
        end
    end

    always_comb begin
        rdata1 = '0;
        rbusy1 = 1'b0;
        if (raddr1 != '0) begin
            if (c_BYPASS && w_we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = r_rf[raddr1];
                rbusy1 = r_pending[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        rbusy2 = 1'b0;
        if (raddr2 != '0) begin
            if (c_BYPASS && w_we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = r_rf[raddr2];
                rbusy2 = r_pending[raddr2];
            end
        end
    end

    assign test_data = (test_addr == '0) ? '0 : r_rf[test_addr];
    assign busy_cnt  = r_busy_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module  : tb_regfile_sb
// Brief   : Directed self-checking bench for regfile_sb (BYPASS=1 and 0).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

    logic        clk;
    logic        resetn;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        mark_en;
    logic [4:0]  mark_addr;
    logic [4:0]  test_addr;

    logic [31:0] rdata1, rdata2, test_data;
    logic        rbusy1, rbusy2;
    logic [5:0]  busy_cnt;

    logic [31:0] nb_rdata1, nb_rdata2, nb_test_data;
    logic        nb_rbusy1, nb_rbusy2;
    logic [5:0]  nb_busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2), .mark_en(mark_en), .mark_addr(mark_addr),
        .busy_cnt(busy_cnt), .test_addr(test_addr), .test_data(test_data)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nb (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rdata1), .rdata2(nb_rdata2),
        .rbusy1(nb_rbusy1), .rbusy2(nb_rbusy2), .mark_en(mark_en), .mark_addr(mark_addr),
        .busy_cnt(nb_busy_cnt), .test_addr(test_addr), .test_data(nb_test_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen     = 1'b0;
        mark_en = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; mark_en = 1'b0; mark_addr = '0; test_addr = '0;
        step();
        resetn = 1'b1;

        // Reset then read
        raddr1 = 5'd5; raddr2 = 5'd31; test_addr = 5'd7;
        #2;
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdata2", rdata2, 32'h0);
        chk("rst_test", test_data, 32'h0);
        chk("rst_rbusy1", {31'b0, rbusy1}, 32'h0);
        chk("rst_rbusy2", {31'b0, rbusy2}, 32'h0);
        chk("rst_cnt", {26'b0, busy_cnt}, 32'h0);

        // Mark of r0 is ignored
        mark_en = 1'b1; mark_addr = 5'd0;
        step(); idle(); #2;
        chk("mark_r0_cnt", {26'b0, busy_cnt}, 32'h0);

        // Write/readback, including ignored write to r0
        wen = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
        step();
        waddr = 5'd0; wdata = 32'h12345678;
        step(); idle();
        raddr1 = 5'd3; raddr2 = 5'd0; test_addr = 5'd3;
        #2;
        chk("wr_rdata1", rdata1, 32'hDEADBEEF);
        chk("wr_rdata2_r0", rdata2, 32'h0);
        chk("wr_test", test_data, 32'hDEADBEEF);
        test_addr = 5'd0; #1;
        chk("wr_test_r0", test_data, 32'h0);

        // Bypass in the write cycle
        wen = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; raddr1 = 5'd9; test_addr = 5'd9;
        #2;
        chk("byp_rdata1", rdata1, 32'hA5A5A5A5);
        chk("byp_test_old", test_data, 32'h0);
        chk("nobyp_rdata1", nb_rdata1, 32'h0);
        step(); idle(); #2;
        chk("byp_rdata1_nxt", rdata1, 32'hA5A5A5A5);
        chk("byp_test_nxt", test_data, 32'hA5A5A5A5);
        chk("nobyp_rdata1_nxt", nb_rdata1, 32'hA5A5A5A5);

        // Scoreboard: mark r4, r4, r6
        mark_en = 1'b1; mark_addr = 5'd4; step();
        mark_addr = 5'd4; step();
        mark_addr = 5'd6; step();
        idle();
        raddr1 = 5'd4; raddr2 = 5'd6;
        #2;
        chk("sb_cnt2", {26'b0, busy_cnt}, 32'd2);
        chk("sb_rbusy1_r4", {31'b0, rbusy1}, 32'd1);
        chk("sb_rbusy2_r6", {31'b0, rbusy2}, 32'd1);
        wen = 1'b1; waddr = 5'd4; wdata = 32'h00001111;
        #2;
        chk("sb_wr_rbusy1", {31'b0, rbusy1}, 32'd0);
        chk("sb_wr_rdata1", rdata1, 32'h00001111);
        chk("nobyp_wr_rbusy1", {31'b0, nb_rbusy1}, 32'd1);
        step(); idle(); #2;
        chk("sb_cnt1", {26'b0, busy_cnt}, 32'd1);
        chk("sb_rbusy1_after", {31'b0, rbusy1}, 32'd0);
        wen = 1'b1; waddr = 5'd8; wdata = 32'h00000008;
        step(); idle(); #2;
        chk("sb_cnt_nonpend", {26'b0, busy_cnt}, 32'd1);

        // Mark and write the same pending register
        mark_en = 1'b1; mark_addr = 5'd6; wen = 1'b1; waddr = 5'd6; wdata = 32'h55;
        step(); idle();
        raddr2 = 5'd6; test_addr = 5'd6;
        #2;
        chk("mw_test", test_data, 32'h55);
        chk("mw_rbusy2", {31'b0, rbusy2}, 32'd1);
        chk("mw_cnt", {26'b0, busy_cnt}, 32'd1);

        // Mark r10 while writing pending r6: net zero
        mark_en = 1'b1; mark_addr = 5'd10; wen = 1'b1; waddr = 5'd6; wdata = 32'h66;
        raddr1 = 5'd10;
        #2;
        chk("mark_same_cyc_rbusy1", {31'b0, rbusy1}, 32'd0);
        step(); idle(); #2;
        chk("mw2_cnt", {26'b0, busy_cnt}, 32'd1);
        chk("mw2_rbusy1_r10", {31'b0, rbusy1}, 32'd1);
        chk("mw2_rbusy2_r6", {31'b0, rbusy2}, 32'd0);
        chk("mw2_test_r6", test_data, 32'h66);

        // Three pending, then reset with concurrent write and mark
        mark_en = 1'b1; mark_addr = 5'd13; step();
        mark_addr = 5'd14; step();
        idle(); #2;
        chk("pre_rst_cnt", {26'b0, busy_cnt}, 32'd3);
        resetn = 1'b0; wen = 1'b1; waddr = 5'd2; wdata = 32'h77; mark_en = 1'b1; mark_addr = 5'd11;
        step();
        resetn = 1'b1; idle();
        raddr1 = 5'd11; raddr2 = 5'd3; test_addr = 5'd2;
        #2;
        chk("mid_rst_cnt", {26'b0, busy_cnt}, 32'd0);
        chk("mid_rst_test_r2", test_data, 32'h0);
        chk("mid_rst_rbusy1_r11", {31'b0, rbusy1}, 32'd0);
        chk("mid_rst_rdata2_r3", rdata2, 32'h0);
        chk("mid_rst_nb_cnt", {26'b0, nb_busy_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
